serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial adder built around a single full-adder slice with a registered carry. It loads two WIDTH-bit operands and a carry-in, then presents one bit pair per clock to the slice, LSB first, carrying between cycles through a flip-flop. It collects sum bits into a result register. It sits directly upstream of the full-adder slice and also consumes that slice's S/Cout outputs, turning the combinational cell into a multi-cycle WIDTH-bit adder with a start/done handshake.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new addition; sampled only when busy=0
a  input  WIDTH  operand A; sampled on the accepting edge only
b  input  WIDTH  operand B; sampled on the accepting edge only
cin  input  1  carry-in; sampled on the accepting edge only
busy  output  1  high while bits are being processed (SHIFT state)
done  output  1  one-cycle pulse when sum/cout become valid
sum  output  WIDTH  registered result; holds until the next completion
cout  output  1  registered final carry; holds until the next completion

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0. Operand shift registers, carry flip-flop and bit counter are all cleared.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if start=1 on an edge, load a, b and cin into internal registers, clear the counter, and go to SHIFT.
  - SHIFT: on each edge, the slice adds a_sh[0], b_sh[0] and carry_q.
    - The slice's sum bit enters the MSB of the accumulator; the accumulator shifts right.
    - carry_q takes the slice's carry-out.
    - a_sh and b_sh shift right.
    - The counter increments.
    - On the edge that processes bit WIDTH-1, copy the accumulator (including the final bit) to sum and the final carry to cout, then go to DONE.
  - DONE: done=1 for exactly this one cycle. If start=1 on this edge, accept a new operation (load, go to SHIFT). Otherwise go to IDLE.
- busy=1 exactly in SHIFT. start is accepted only when busy=0 (IDLE or DONE). start while busy is ignored, with no effect on the operation in flight.
- Latency: if start is accepted at edge k, SHIFT occupies the cycles between edges k and k+WIDTH. done is high in the cycle after edge k+WIDTH, i.e. WIDTH cycles after the accept edge. Back-to-back operations accepted in DONE give a throughput of one result per WIDTH+1 cycles.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, WIDTH+1 bits exact. Wrap-around is expressed only through cout.
- sum and cout change only on completion edges. They are stable in IDLE, SHIFT and DONE otherwise.
- The counter is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.
- Reset asserted mid-operation: the operation aborts immediately; no done pulse is produced and sum/cout read 0. After rst_n is released, the next start behaves normally.
- a, b and cin may change freely while busy; only the values on the accept edge matter.

Optional Feature:
Macro SERIAL_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit) for two's-complement overflow.
  - ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
  - The carry into bit WIDTH-1 is carry_q at the start of the final SHIFT cycle.
  - ovf is registered on the same edge as sum and cout, and resets to 0.
- Undefined: no ovf port or logic; all other behaviour is identical.

Test Plan:
- Basic add: WIDTH=8, start with a=8'h0F, b=8'h01, cin=0 -> busy high for 8 cycles, then done for one cycle; sum=8'h10, cout=0; done exactly 8 cycles after the accept edge.
- Wrap: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Ignored start: accept a=8'h12, b=8'h34; pulse start with a=8'hAA, b=8'h55 during SHIFT -> result is sum=8'h46, cout=0; exactly one done pulse; FSM returns to IDLE.
- Back-to-back: hold start=1 with a=8'h01, b=8'h01, then switch to a=8'h80, b=8'h80 in the DONE cycle -> first result sum=8'h02; second accepted in DONE gives sum=8'h00, cout=1 at WIDTH+1 cycles spacing; busy low only during the DONE cycle.
- Reset mid-op: accept a=8'hF0, b=8'h0F; drop rst_n after 4 SHIFT cycles -> busy, done, sum and cout go 0 immediately with no done pulse. After release, a=8'h03, b=8'h04 gives sum=8'h07.
- OVF (SERIAL_ADDER_OVF_EN defined):
  - a=8'h7F, b=8'h01 -> sum=8'h80, ovf=1, cout=0.
  - a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
  - a=8'hFF, b=8'h01 -> ovf=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder slice, registered carry, start/done handshake.
// Optional two's-complement overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               w_s;
  logic               w_co;
  logic [WIDTH-1:0]   w_acc_nx;

  // Full-adder slice on the current LSBs plus the carry flop
  assign w_s      = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_co     = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
  assign w_acc_nx = {w_s, r_acc[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_last     = 1'b1;
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_state_nx = S_SHIFT;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Handshake outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nx == S_SHIFT);
      r_done <= (w_state_nx == S_DONE);
    end
  end

  // Operand shifters, carry, counter and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_carry <= w_co;
      r_acc   <= w_acc_nx;
      // Wrap to zero on the last bit so the counter never passes WIDTH-1
      r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Result registers update only on the completion edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_last) begin
      r_sum  <= w_acc_nx;
      r_cout <= w_co;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // Carry into the MSB is the carry flop during the final SHIFT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= r_carry ^ w_co;
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed table-driven bench for serial_adder_ctrl at WIDTH=8, plus multi-cycle corner sequences.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One complete operation from an idle DUT, checking latency, busy span and result
  task automatic run_op(input vec_t v, input string tag);
    int n;
    int nbusy;
    bit got;
    n = 0; nbusy = 0; got = 1'b0;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'h5C; b = 8'hC5; cin = ~v.cin;
    while (n < 20 && !got) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) nbusy++;
        @(negedge clk);
        n++;
      end
    end
    chk($sformatf("%s done_seen", tag), 32'(got), 32'd1);
    chk($sformatf("%s latency", tag), 32'(n), 32'd8);
    chk($sformatf("%s busy_cycles", tag), 32'(nbusy), 32'd8);
    chk($sformatf("%s busy_in_done", tag), 32'(busy), 32'd0);
    chk($sformatf("%s sum", tag), 32'(sum), 32'(v.s));
    chk($sformatf("%s cout", tag), 32'(cout), 32'(v.co));
`ifdef SERIAL_ADDER_OVF_EN
    chk($sformatf("%s ovf", tag), 32'(ovf), 32'(v.ov));
`endif
    @(negedge clk);
    chk($sformatf("%s done_single", tag), 32'(done), 32'd0);
    chk($sformatf("%s idle_busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s sum_hold", tag), 32'(sum), 32'(v.s));
  endtask

  initial begin
    int ndone;
    int first;
    int t;
    int t1;
    int t2;
    int nlow;
    vec_t v;

    vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, s: 8'h10, co: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, co: 1'b1, ov: 1'b0};
    vecs[3] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, co: 1'b0, ov: 1'b1};
    vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b1};
    vecs[5] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, co: 1'b0, ov: 1'b0};
    vecs[6] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, s: 8'h00, co: 1'b1, ov: 1'b0};
    vecs[7] = '{a: 8'h12, b: 8'h34, cin: 1'b1, s: 8'h47, co: 1'b0, ov: 1'b0};

    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset ovf", 32'(ovf), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Start pulsed mid-SHIFT must be ignored
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    ndone = 0; first = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (i == 3) begin a = 8'hAA; b = 8'h55; start = 1'b1; end
      if (i == 4) start = 1'b0;
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = i;
          chk("ign sum", 32'(sum), 32'h46);
          chk("ign cout", 32'(cout), 32'd0);
        end
      end
    end
    chk("ign done_count", 32'(ndone), 32'd1);
    chk("ign latency", 32'(first), 32'd8);
    chk("ign idle_busy", 32'(busy), 32'd0);
    chk("ign sum_hold", 32'(sum), 32'h46);

    // Back-to-back: second op accepted in the DONE cycle
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    t = 0; t1 = -1; t2 = -1; nlow = 0;
    while (t < 40 && t2 < 0) begin
      @(posedge clk);
      @(negedge clk);
      t++;
      if (t1 >= 0 && t == t1 + 1) start = 1'b0;
      if (done) begin
        if (t1 < 0) begin
          t1 = t;
          chk("b2b sum1", 32'(sum), 32'h02);
          chk("b2b cout1", 32'(cout), 32'd0);
          a = 8'h80; b = 8'h80;
        end else begin
          t2 = t;
          chk("b2b sum2", 32'(sum), 32'h00);
          chk("b2b cout2", 32'(cout), 32'd1);
        end
      end else if (!busy) begin
        nlow++;
      end
      if (done && busy) nlow = nlow + 100;
      if (done && t2 < 0) nlow++;
    end
    start = 1'b0;
    chk("b2b first_latency", 32'(t1), 32'd9);
    chk("b2b spacing", 32'(t2 - t1), 32'd9);
    chk("b2b busy_low_cycles", 32'(nlow), 32'd1);

    // Reset asserted mid-operation
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid busy_before", 32'(busy), 32'd1);
    chk("rst_mid cout_before", 32'(cout), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid done", 32'(done), 32'd0);
    chk("rst_mid sum", 32'(sum), 32'd0);
    chk("rst_mid cout", 32'(cout), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done) ndone++;
    end
    chk("rst_mid no_done", 32'(ndone), 32'd0);
    chk("rst_mid sum_after", 32'(sum), 32'd0);
    v = '{a: 8'h03, b: 8'h04, cin: 1'b0, s: 8'h07, co: 1'b0, ov: 1'b0};
    run_op(v, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
